ifid_queue: RTL
===============

# ifid_queue

Parametrised IF/ID pipeline stage for the CPU pipeline. It sits between instruction fetch and decode. It replaces a single-entry IF/ID register with a DEPTH-entry in-order instruction buffer, so fetch can run ahead while decode stalls. It adds a valid/ready handshake on both sides, a flush that discards all buffered instructions, and occupancy status.

## Interface
- INST_W, default 32: instruction width.
- ADDR_W, default 64: instruction address width.
- DEPTH, default 4: buffer entries; power of two, at least 2.
- BUBBLE, default 0: value driven on o_inst when no valid instruction is presented (NOP).
- CNT_W, default $clog2(DEPTH)+1: occupancy counter width (localparam).

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_inst  in  INST_W  fetched instruction.
- i_inst_addr  in  ADDR_W  PC of i_inst.
- i_valid  in  1  fetch presents an instruction.
- o_ready  out  1  buffer can accept (not full).
- i_flush  in  1  discard all contents (branch/jump resolve).
- o_inst  out  INST_W  head instruction, or BUBBLE when empty.
- o_inst_addr  out  ADDR_W  head PC, or 0 when empty.
- o_valid  out  1  head entry valid.
- i_ready  in  1  decode consumes the head this cycle (deasserted on hazard stall).
- o_count  out  CNT_W  entries held.
- o_full  out  1  o_count == DEPTH.
- o_empty  out  1  o_count == 0.

## Operation
- Push when i_valid && o_ready. Pop when o_valid && i_ready. Flush when i_flush.
- Storage is circular: write pointer wp and read pointer rp, each CNT_W bits. The MSB is the wrap bit.
  - Full: index bits are equal and the wrap bits differ.
  - Empty: wp == rp.
- Pointers increment modulo 2^CNT_W. Index = pointer[CNT_W-2:0].
- o_ready = ~o_full. There is no combinational path from i_ready to o_ready. When full, a same-cycle pop does not enable a push.
- Simultaneous push and pop when not full and not empty: both happen, and o_count is unchanged.
- Push while empty: the entry becomes the head next cycle. There is no bypass.
- Flush has priority over push and pop. On the next edge wp <= rp, so o_count = 0. Any same-cycle push is dropped and any same-cycle pop is ignored.
- Outputs (head = storage[rp index]):
  - When o_empty, o_inst = BUBBLE and o_inst_addr = 0.
  - Otherwise o_inst and o_inst_addr equal the head entry.
  - o_valid = ~o_empty.
- Order is strictly preserved. No entry is duplicated or skipped.
- Storage contents are not reset. Only the pointers are reset, and outputs are masked by empty.

## Timing
- Reset (async assert, sync release):
  - wp = rp = 0, o_count = 0.
  - o_empty = 1, o_full = 0, o_ready = 1, o_valid = 0.
  - o_inst = BUBBLE, o_inst_addr = 0.
- Push-to-output latency: 1 cycle. An instruction accepted at edge N appears on o_inst after edge N, if the buffer was empty.
- Throughput: 1 push and 1 pop per cycle sustained, as long as the buffer is neither empty nor full.
- Stall: hold i_ready = 0. The head stays stable, and the buffer fills to DEPTH, after which o_ready = 0.
- Flush: o_valid = 0 and o_inst = BUBBLE from the cycle after i_flush. The first push is accepted in that same cycle.
- Reset mid-operation: all state clears immediately, asynchronously. No partial entries survive.

## Structure
- Shared package ifid_pkg:
  - BUBBLE_NOP constant (32'h0).
  - Default INST_W and ADDR_W.
  - typedef ifid_entry_t struct {inst, addr}, reused by ID/EX.
- One sub-module is natural: ifid_buf_mem, a DEPTH x (INST_W+ADDR_W) register array with one write port and an asynchronous read port.
- Pointer, flush and status logic live in ifid_queue.

## Test plan
- Reset then idle: o_valid=0, o_inst=0, o_ready=1, o_count=0. Assert i_rst mid-stream with 3 entries held: all outputs return to reset values without waiting for a clock edge.
- Stream: push PC 0x0, 0x4, 0x8 with i_inst 0x11, 0x22, 0x33 and i_ready=1 constant. The outputs show each instruction one cycle after it is pushed, in order, and o_count never exceeds 1.
- Stall fill: i_ready=0, push 5 instructions at DEPTH=4. The first 4 are accepted, o_full=1 and o_ready=0, and the 5th is held by fetch. Release i_ready: the outputs drain in order 0x0…0xC.
- Flush: with 3 entries held, assert i_flush together with i_valid (PC 0x40). Next cycle o_count=0, o_valid=0 and PC 0x40 is absent. A push of PC 0x80 appears on the following cycle.
- Wrap-around: 20 push/pop cycles at DEPTH=4 with random i_ready. The output sequence matches a reference queue exactly, and the full/empty flags are correct across pointer wrap.
- Full plus pop: when full, i_ready=1 and i_valid=1. The head pops, the push is refused (o_ready=0 that cycle), and o_count goes 4→3.

Source files
------------

// File: rtl/ifid_pkg.sv
// Shared IF/ID definitions: default widths, the NOP bubble and the
// instruction/PC bundle handed from fetch toward ID/EX.
package ifid_pkg;

    localparam int INST_W_DEF = 32;
    localparam int ADDR_W_DEF = 64;

    localparam logic [31:0] BUBBLE_NOP = 32'h0;

    typedef struct packed {
        logic [INST_W_DEF-1:0] inst;
        logic [ADDR_W_DEF-1:0] addr;
    } ifid_entry_t;

endpackage

// File: rtl/ifid_buf_mem.sv
// Instruction buffer storage: one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module ifid_buf_mem #(
    parameter int W     = 96,
    parameter int DEPTH = 4,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [IDX_W-1:0] i_waddr,
    input  logic [W-1:0]     i_wdata,
    input  logic [IDX_W-1:0] i_raddr,
    output logic [W-1:0]     o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifid_queue.sv
// IF/ID stage as a DEPTH-entry in-order instruction buffer with
// valid/ready handshakes on both sides, flush and occupancy status.
module ifid_queue
    import ifid_pkg::*;
#(
    parameter int                INST_W = INST_W_DEF,
    parameter int                ADDR_W = ADDR_W_DEF,
    parameter int                DEPTH  = 4,
    parameter logic [INST_W-1:0] BUBBLE = INST_W'(BUBBLE_NOP),
    localparam int               CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [INST_W-1:0] i_inst,
    input  logic [ADDR_W-1:0] i_inst_addr,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_flush,
    output logic [INST_W-1:0] o_inst,
    output logic [ADDR_W-1:0] o_inst_addr,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [CNT_W-1:0]  o_count,
    output logic              o_full,
    output logic              o_empty
);

    localparam int IDX_W = CNT_W - 1;
    localparam int ENT_W = INST_W + ADDR_W;

    logic [CNT_W-1:0] r_wp;
    logic [CNT_W-1:0] r_rp;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_wdata;
    logic [ENT_W-1:0] w_rdata;

    assign w_empty = (r_wp == r_rp);
    assign w_full  = (r_wp[IDX_W-1:0] == r_rp[IDX_W-1:0]) &&
                     (r_wp[CNT_W-1] != r_rp[CNT_W-1]);

    // Ready depends only on stored state, never on i_ready.
    assign w_push = i_valid && !w_full;
    assign w_pop  = !w_empty && i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else if (i_flush) begin
            r_wp <= r_rp;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
        end
    end

    assign w_wdata = {i_inst, i_inst_addr};

    ifid_buf_mem #(
        .W     (ENT_W),
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push && !i_flush),
        .i_waddr (r_wp[IDX_W-1:0]),
        .i_wdata (w_wdata),
        .i_raddr (r_rp[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign o_inst      = w_empty ? BUBBLE : w_rdata[ENT_W-1 -: INST_W];
    assign o_inst_addr = w_empty ? '0 : w_rdata[ADDR_W-1:0];
    assign o_valid     = !w_empty;
    assign o_ready     = !w_full;
    assign o_count     = r_wp - r_rp;
    assign o_full      = w_full;
    assign o_empty     = w_empty;

endmodule
